// File: rtl/dp_pkg.sv
// dp_pkg: shared state encoding, instruction field positions and shifter op codes for dp_ctrl
package dp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_EXEC, S_WB, S_FIN} state_t;
    typedef enum logic [1:0] {ST_HOLD = 2'b00, ST_LOAD = 2'b01, ST_SHL = 2'b10, ST_SHR = 2'b11} st_op_t;
    localparam int ALU_HI = 11;
    localparam int ALU_LO = 8;
    localparam int ST_HI = 7;
    localparam int ST_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 4;
    localparam int RS_HI = 3;
    localparam int RS_LO = 2;
    localparam int IMM_SEL_BIT = 1;
    localparam int WB_BIT = 0;
endpackage

// File: rtl/dp_ctrl.sv
// dp_ctrl: datapath sequencer that runs one instruction through LOAD_A, EXEC, optional WB and FIN
//   CLK/RESET     : clock, asynchronous active-low reset
//   START/INSTR/IMM : request, instruction word and immediate (latched in IDLE)
//   Ace/GRSce/PSWce : write enables for A, register file, PSW
//   ALU_OP/ST_OP  : ALU and shifter op codes (valid in EXEC)
//   DATAoe/GRSoe/Soe: bus-driver enables; INDEX/DATA: register index and immediate bus
//   BUSY/DONE     : not-idle flag and one-cycle completion pulse
module dp_ctrl
    import dp_pkg::*;
#(
    parameter int DATAWIDTH  = 4,
    parameter int INDEXWIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [11:0]           INSTR,
    input  logic [DATAWIDTH-1:0]  IMM,
    output logic                  Ace,
    output logic                  GRSce,
    output logic                  PSWce,
    output logic [3:0]            ALU_OP,
    output logic [1:0]            ST_OP,
    output logic                  DATAoe,
    output logic                  GRSoe,
    output logic                  Soe,
    output logic [INDEXWIDTH-1:0] INDEX,
    output logic [DATAWIDTH-1:0]  DATA,
    output logic                  BUSY,
    output logic                  DONE
);
    state_t               state;
    logic [11:0]          ir;
    logic [DATAWIDTH-1:0] imm_q;

    // Outputs are computed for the state being entered, so they are valid
    // for the whole cycle that state occupies.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= S_IDLE;
            ir     <= '0;
            imm_q  <= '0;
            Ace    <= 1'b0;
            GRSce  <= 1'b0;
            PSWce  <= 1'b0;
            ALU_OP <= '0;
            ST_OP  <= ST_HOLD;
            DATAoe <= 1'b0;
            GRSoe  <= 1'b0;
            Soe    <= 1'b0;
            INDEX  <= '0;
            DATA   <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            Ace    <= 1'b0;
            GRSce  <= 1'b0;
            PSWce  <= 1'b0;
            ALU_OP <= '0;
            ST_OP  <= ST_HOLD;
            DATAoe <= 1'b0;
            GRSoe  <= 1'b0;
            Soe    <= 1'b0;
            INDEX  <= '0;
            DATA   <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            case (state)
                S_IDLE: if (START) begin
                    ir    <= INSTR;
                    imm_q <= IMM;
                    state <= S_LOAD_A;
                    BUSY  <= 1'b1;
                    GRSoe <= 1'b1;
                    Ace   <= 1'b1;
                    // ir is not yet loaded on this edge, so RD comes straight from INSTR
                    INDEX <= INDEXWIDTH'(INSTR[RD_HI:RD_LO]);
                end
                S_LOAD_A: begin
                    state  <= S_EXEC;
                    BUSY   <= 1'b1;
                    ALU_OP <= ir[ALU_HI:ALU_LO];
                    ST_OP  <= ir[ST_HI:ST_LO];
                    PSWce  <= 1'b1;
                    DATAoe <= ir[IMM_SEL_BIT];
                    GRSoe  <= !ir[IMM_SEL_BIT];
                    DATA   <= ir[IMM_SEL_BIT] ? imm_q : '0;
                    INDEX  <= ir[IMM_SEL_BIT] ? '0 : INDEXWIDTH'(ir[RS_HI:RS_LO]);
                end
                S_EXEC: begin
                    state <= ir[WB_BIT] ? S_WB : S_FIN;
                    BUSY  <= 1'b1;
                    Soe   <= ir[WB_BIT];
                    GRSce <= ir[WB_BIT];
                    INDEX <= ir[WB_BIT] ? INDEXWIDTH'(ir[RD_HI:RD_LO]) : '0;
                    DONE  <= !ir[WB_BIT];
                end
                S_WB: begin
                    state <= S_FIN;
                    BUSY  <= 1'b1;
                    DONE  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_ctrl.sv
// tb_dp_ctrl: randomized and directed checks of dp_ctrl against a per-cycle expected-output queue
module tb_dp_ctrl;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [11:0] INSTR = '0;
    logic [3:0]  IMM = '0;
    logic        Ace, GRSce, PSWce, DATAoe, GRSoe, Soe, BUSY, DONE;
    logic [3:0]  ALU_OP;
    logic [1:0]  ST_OP, INDEX;
    logic [3:0]  DATA;

    dp_ctrl dut (
        .CLK(CLK), .RESET(RESET), .START(START), .INSTR(INSTR), .IMM(IMM),
        .Ace(Ace), .GRSce(GRSce), .PSWce(PSWce), .ALU_OP(ALU_OP), .ST_OP(ST_OP),
        .DATAoe(DATAoe), .GRSoe(GRSoe), .Soe(Soe), .INDEX(INDEX), .DATA(DATA),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ace, grsce, pswce;
        logic [3:0] alu;
        logic [1:0] st;
        logic       doe, goe, soe;
        logic [1:0] idx;
        logic [3:0] dat;
        logic       busy, done;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   accepted = 0;
    bit   chk_en = 0;
    out_t q[$];
    out_t exp_o;
    out_t e;
    out_t dut_o;

    assign dut_o = '{Ace, GRSce, PSWce, ALU_OP, ST_OP, DATAoe, GRSoe, Soe, INDEX, DATA, BUSY, DONE};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: an accepted instruction expands into the list of per-cycle
    // output sets it must produce, ending with one idle cycle spent leaving FIN.
    always @(posedge CLK) begin
        if (!RESET) begin
            q.delete();
            exp_o = '0;
        end else begin
            if (q.size() == 0 && START) begin
                e = '0; e.busy = 1'b1; e.goe = 1'b1; e.ace = 1'b1; e.idx = INSTR[5:4];
                q.push_back(e);
                e = '0; e.busy = 1'b1; e.alu = INSTR[11:8]; e.st = INSTR[7:6]; e.pswce = 1'b1;
                if (INSTR[1]) begin e.doe = 1'b1; e.dat = IMM; end
                else begin e.goe = 1'b1; e.idx = INSTR[3:2]; end
                q.push_back(e);
                if (INSTR[0]) begin
                    e = '0; e.busy = 1'b1; e.soe = 1'b1; e.grsce = 1'b1; e.idx = INSTR[5:4];
                    q.push_back(e);
                end
                e = '0; e.busy = 1'b1; e.done = 1'b1;
                q.push_back(e);
                q.push_back('0);
                accepted++;
            end
            exp_o = q.size() != 0 ? q.pop_front() : '0;
        end
    end

    always @(negedge RESET) begin
        q.delete();
        exp_o = '0;
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc", 32'(dut_o), 32'(exp_o));
            if (DONE) dones++;
            assert ($countones({DATAoe, GRSoe, Soe}) <= 1)
                else $error("FAIL oe_onehot got=%b exp=at most one", {DATAoe, GRSoe, Soe});
        end
    end

    task automatic run_op(input string tag, input logic [11:0] ins, input logic [3:0] im, input int lat_exp);
        int lat;
        START = 1'b1;
        INSTR = ins;
        IMM   = im;
        lat   = 0;
        do begin
            @(negedge CLK);
            START = 1'b0;
            lat++;
        end while (!DONE && lat < 10);
        check(tag, 32'(lat), 32'(lat_exp));
        @(negedge CLK);
    endtask

    initial begin
        int grs, d0, a0, n;
        #3 RESET = 1'b0;
        @(negedge CLK);
        check("reset", 32'(dut_o), 32'h0);
        chk_en = 1;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        run_op("lat_reg_wb",  {4'd1, 2'b01, 2'd1, 2'd2, 1'b0, 1'b1}, 4'h0, 4);
        run_op("lat_imm_nowb", {4'd3, 2'b10, 2'd2, 2'd3, 1'b1, 1'b0}, 4'hA, 3);
        run_op("lat_rd_eq_rs", {4'd5, 2'b11, 2'd3, 2'd3, 1'b0, 1'b1}, 4'h5, 4);
        run_op("lat_imm_wb",  {4'd15, 2'b00, 2'd0, 2'd1, 1'b1, 1'b1}, 4'hF, 4);
        run_op("lat_reg_nowb", {4'd8, 2'b01, 2'd2, 2'd0, 1'b0, 1'b0}, 4'h3, 3);
        // busy handling: keep requesting with new instructions while busy
        d0 = dones;
        START = 1'b1;
        INSTR = {4'd6, 2'b10, 2'd1, 2'd3, 1'b0, 1'b1};
        IMM = 4'h2;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            INSTR = 12'($urandom);
            IMM = 4'($urandom);
            START = BUSY;
        end while (BUSY && n < 10);
        START = 1'b0;
        @(negedge CLK);
        check("busy_dones", 32'(dones - d0), 32'd1);
        check("busy_len", 32'(n), 32'd5);
        // reset in the middle of EXEC
        START = 1'b1;
        INSTR = {4'd2, 2'b01, 2'd3, 2'd1, 1'b0, 1'b1};
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("in_exec", 32'(PSWce), 32'd1);
        #2 RESET = 1'b0;
        #1 check("rst_async", 32'(dut_o), 32'h0);
        grs = 0;
        repeat (3) begin @(negedge CLK); grs += int'(GRSce); end
        RESET = 1'b1;
        repeat (3) begin @(negedge CLK); grs += int'(GRSce); end
        check("no_grsce", 32'(grs), 32'd0);
        // start right on the first edge after reset release
        #2 RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        run_op("after_rst", {4'd9, 2'b11, 2'd2, 2'd2, 1'b0, 1'b1}, 4'h0, 4);
        // random back-to-back traffic
        d0 = dones;
        a0 = accepted;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            START = ($urandom_range(0, 3) != 0);
            INSTR = 12'($urandom);
            IMM = 4'($urandom);
        end
        START = 1'b0;
        repeat (8) @(negedge CLK);
        check("done_vs_acc", 32'(dones - d0), 32'(accepted - a0));
        check("rand_idle", 32'(BUSY), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
